// File: rtl/stepper_pkg.sv
// Shared stepper definitions: step-size/direction encodings, phase index type
// and the 8-entry coil phase table, shared with the step-rate counter.
package stepper_pkg;

  localparam logic FULL_STEP = 1'b0;
  localparam logic HALF_STEP = 1'b1;
  localparam logic DIR_CW    = 1'b0;
  localparam logic DIR_CCW   = 1'b1;

  typedef logic [2:0] phase_idx_t;

  // Entry n lives in slice [n], so PHASE_TABLE[idx] gives the {A,B,A_n,B_n} pattern.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  function automatic logic [3:0] phase_coils(input phase_idx_t idx);
    return PHASE_TABLE[idx];
  endfunction

endpackage

// File: rtl/step_hold_timer.sv
// Idle counter for coil hold timeout: clears on each accepted step and
// saturates at HOLD_CYCLES. Only built when HOLD_TIMEOUT_EN is defined.
module step_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic saturated
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1) < 1 ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign saturated = (count_q == CNT_MAX);

endmodule

// File: rtl/step_phase_sequencer.sv
// Stepper phase sequencer: edge-detects step pulses, walks the phase table,
// tracks half-step shaft position and flags revolutions. Optional coil hold
// timeout is enabled with the HOLD_TIMEOUT_EN macro.
module step_phase_sequencer
  import stepper_pkg::*;
#(
  parameter int unsigned STEPS_PER_REV = 200,
  parameter int unsigned HOLD_CYCLES   = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       step_pulse,
  input  logic       step_size_sw,
  input  logic       direction,
  output logic [3:0] coils,
  output logic [8:0] position,
  output logic       rev_done,
  output logic       stepping
);

  localparam logic [9:0] REV_HALF = 10'(2 * STEPS_PER_REV);

  // Returns {wrapped, new_position} for a move of inc half-steps.
  function automatic logic [9:0] pos_advance(input logic [8:0] pos,
                                             input logic [1:0] inc,
                                             input logic       ccw);
    logic [9:0] ext;
    logic [9:0] ext_inc;
    logic [9:0] sum;
    ext     = {1'b0, pos};
    ext_inc = {8'b0, inc};
    sum     = ext + ext_inc;
    if (ccw) begin
      if (ext < ext_inc) begin
        return {1'b1, 9'(ext + REV_HALF - ext_inc)};
      end
      return {1'b0, 9'(ext - ext_inc)};
    end
    if (sum >= REV_HALF) begin
      return {1'b1, 9'(sum - REV_HALF)};
    end
    return {1'b0, sum[8:0]};
  endfunction

  logic       step_prev_q, step_prev_d;
  phase_idx_t idx_q, idx_d;
  logic [8:0] pos_q, pos_d;
  logic [3:0] coils_q, coils_d;
  logic       rev_done_q, rev_done_d;
  logic       stepping_q, stepping_d;
  logic       accept;
  logic [1:0] inc;
  logic       hold_sat;

`ifdef HOLD_TIMEOUT_EN
  step_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .saturated(hold_sat)
  );
`else
  // No idle counter; the parameter is still referenced so both builds share one interface.
  assign hold_sat = 1'b0 & (HOLD_CYCLES == 0);
`endif

  always_comb begin
    step_prev_d = step_pulse;
    accept      = step_pulse & ~step_prev_q & enable;
    // An odd index in full-step mode takes a single half-step to realign to even.
    inc         = (step_size_sw == HALF_STEP || idx_q[0]) ? 2'd1 : 2'd2;
    idx_d       = idx_q;
    pos_d       = pos_q;
    rev_done_d  = 1'b0;
    stepping_d  = accept;
    if (accept) begin
      if (direction == DIR_CCW) begin
        idx_d = idx_q - phase_idx_t'(inc);
      end else begin
        idx_d = idx_q + phase_idx_t'(inc);
      end
      {rev_done_d, pos_d} = pos_advance(pos_q, inc, direction == DIR_CCW);
    end
    coils_d = (enable && !(hold_sat && !accept)) ? phase_coils(idx_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_prev_q <= 1'b0;
      idx_q       <= '0;
      pos_q       <= '0;
      coils_q     <= 4'b0000;
      rev_done_q  <= 1'b0;
      stepping_q  <= 1'b0;
    end else begin
      step_prev_q <= step_prev_d;
      idx_q       <= idx_d;
      pos_q       <= pos_d;
      coils_q     <= coils_d;
      rev_done_q  <= rev_done_d;
      stepping_q  <= stepping_d;
    end
  end

  assign coils    = coils_q;
  assign position = pos_q;
  assign rev_done = rev_done_q;
  assign stepping = stepping_q;

endmodule

// File: tb/tb_step_phase_sequencer.sv
// Scoreboard bench for step_phase_sequencer: a half-step position/phase model
// predicts each step's coils, position and rev_done; a monitor compares them.
module tb_step_phase_sequencer;

  localparam int SPR  = 200;
  localparam int REVH = 2 * SPR;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       step_pulse;
  logic       step_size_sw;
  logic       direction;
  logic [3:0] coils;
  logic [8:0] position;
  logic       rev_done;
  logic       stepping;

  step_phase_sequencer #(
    .STEPS_PER_REV(SPR),
    .HOLD_CYCLES  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .step_pulse  (step_pulse),
    .step_size_sw(step_size_sw),
    .direction   (direction),
    .coils       (coils),
    .position    (position),
    .rev_done    (rev_done),
    .stepping    (stepping)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] coils;
    int         pos;
    bit         rev;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] tbl[8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                         4'b0010, 4'b0011, 4'b0001, 4'b1001};
  int model_idx = 0;
  int model_pos = 0;
  int passed = 0;
  int total = 0;
  int steps_pushed = 0;
  int steps_seen = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference: phase index mod 8, position mod 2*SPR in half-step units.
  task automatic model_step(input bit ccw, input bit half);
    exp_t e;
    int   inc;
    int   np;
    inc = (half || (model_idx % 2 == 1)) ? 1 : 2;
    np  = ccw ? model_pos - inc : model_pos + inc;
    model_idx = ccw ? (model_idx - inc + 8) % 8 : (model_idx + inc) % 8;
    e.rev = (np < 0) || (np >= REVH);
    model_pos = (np + REVH) % REVH;
    e.coils = tbl[model_idx];
    e.pos   = model_pos;
    exp_q.push_back(e);
    steps_pushed++;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("rev_only_with_step", int'(rev_done && !stepping), 0);
      if (stepping) begin
        steps_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_step", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("coils", int'(coils), int'(e.coils));
          chk("position", int'(position), e.pos);
          chk("rev_done", int'(rev_done), int'(e.rev));
        end
      end
    end
  end

  task automatic step(input bit ccw, input bit half, input int gap);
    @(negedge clk);
    direction    = ccw;
    step_size_sw = half;
    step_pulse   = 1'b1;
    if (enable) model_step(ccw, half);
    @(negedge clk);
    step_pulse = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_coils", int'(coils), 0);
    chk("reset_position", int'(position), 0);
    chk("reset_stepping", int'(stepping), 0);
    chk("reset_rev_done", int'(rev_done), 0);
    reset = 1'b0;
    model_idx = 0;
    model_pos = 0;
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    step_pulse   = 1'b0;
    step_size_sw = 1'b0;
    direction    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_coils_init", int'(coils), 0);
    chk("reset_position_init", int'(position), 0);
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("energize_idx0", int'(coils), int'(tbl[0]));

    // Half step CW walk through the whole table
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 0);

    // Full step CCW from origin wraps below zero
    do_reset();
    step(1'b1, 1'b0, 1);

    // Half to odd index, then full CW realigns
    do_reset();
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1);

    // Level held high gives one step
    @(negedge clk);
    direction    = 1'b0;
    step_size_sw = 1'b1;
    step_pulse   = 1'b1;
    model_step(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    step_pulse = 1'b0;
    @(negedge clk);

    // Disable: coils off, steps ignored, state retained
    enable = 1'b0;
    @(negedge clk);
    chk("disabled_coils", int'(coils), 0);
    step(1'b0, 1'b0, 1);
    chk("disabled_position", int'(position), model_pos);
    chk("disabled_coils_after_pulse", int'(coils), 0);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable_coils", int'(coils), int'(tbl[model_idx]));

    // Enable falls in the same cycle as the step edge
    @(negedge clk);
    enable     = 1'b0;
    step_pulse = 1'b1;
    @(negedge clk);
    step_pulse = 1'b0;
    enable     = 1'b1;
    repeat (2) @(negedge clk);
    chk("dropped_step_position", int'(position), model_pos);

    // Idle behaviour of the coils
    repeat (25) @(negedge clk);
`ifdef HOLD_TIMEOUT_EN
    chk("hold_timeout_coils", int'(coils), 0);
    step(1'b0, 1'b1, 1);
`else
    chk("idle_coils_energized", int'(coils), int'(tbl[model_idx]));
`endif

    // Full CW revolution in half steps wraps to zero
    do_reset();
    for (int i = 0; i < REVH; i++) step(1'b0, 1'b1, 0);

    // Random walk with occasional disable
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) enable = 1'b0;
      else enable = 1'b1;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    enable = 1'b1;

    drain();
    chk("step_count", steps_seen, steps_pushed);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
